// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU: captures decoded fields, applies operand forwarding,
// detects load-use hazards. Optional stall/flush event counter is enabled by macro ID_EX_STALL_CNT_EN.
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_id_valid,
  input  logic [3:0]         i_id_op_code,
  input  logic [REGBITS-1:0] i_id_rs,
  input  logic [REGBITS-1:0] i_id_rt,
  input  logic [REGBITS-1:0] i_id_rd,
  input  logic [WIDTH-1:0]   i_id_rs_val,
  input  logic [WIDTH-1:0]   i_id_rt_val,
  input  logic [WIDTH-1:0]   i_id_imm,
  input  logic               i_id_use_imm,
  input  logic               i_id_reg_write,
  input  logic               i_id_mem_read,
  input  logic               i_flush,
  input  logic               i_ex_mem_reg_write,
  input  logic [REGBITS-1:0] i_ex_mem_rd,
  input  logic [WIDTH-1:0]   i_ex_mem_val,
  input  logic               i_mem_wb_reg_write,
  input  logic [REGBITS-1:0] i_mem_wb_rd,
  input  logic [WIDTH-1:0]   i_mem_wb_val,
  output logic               o_stall,
  output logic [3:0]         o_alu_op_code,
  output logic [WIDTH-1:0]   o_alu_a,
  output logic [WIDTH-1:0]   o_alu_b,
  output logic               o_ex_valid,
  output logic               o_ex_reg_write,
  output logic               o_ex_mem_read,
  output logic [REGBITS-1:0] o_ex_rd,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]        o_stall_count,
`endif
  output logic [WIDTH-1:0]   o_ex_rt_val
);

  logic               r_valid;
  logic               r_reg_write;
  logic               r_mem_read;
  logic [REGBITS-1:0] r_rd;
  logic [3:0]         r_op_code;
  logic [WIDTH-1:0]   r_imm;
  logic               r_use_imm;
  logic [REGBITS-1:0] r_src [2];
  logic [WIDTH-1:0]   r_val [2];

  logic [REGBITS-1:0] w_id_src [2];
  logic [WIDTH-1:0]   w_id_val [2];
  logic [WIDTH-1:0]   w_cap_val [2];
  logic [WIDTH-1:0]   w_fwd [2];
  logic               w_stall;
  logic               w_capture;

  assign w_id_src[0] = i_id_rs;
  assign w_id_src[1] = i_id_rt;
  assign w_id_val[0] = i_id_rs_val;
  assign w_id_val[1] = i_id_rt_val;

  // Index 0 is the rs/A operand, index 1 the rt/B operand.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign w_cap_val[gi] = (i_mem_wb_reg_write && (i_mem_wb_rd != '0) && (i_mem_wb_rd == w_id_src[gi]))
                             ? i_mem_wb_val : w_id_val[gi];
      assign w_fwd[gi] = (i_ex_mem_reg_write && (i_ex_mem_rd != '0) && (i_ex_mem_rd == r_src[gi])) ? i_ex_mem_val :
                         (i_mem_wb_reg_write && (i_mem_wb_rd != '0) && (i_mem_wb_rd == r_src[gi])) ? i_mem_wb_val :
                         r_val[gi];
    end
  endgenerate

  // A load in EX cannot forward to the instruction behind it; hold ID for one cycle.
  assign w_stall = i_id_valid & r_valid & r_mem_read & (r_rd != '0) &
                   ((i_id_rs == r_rd) | (~i_id_use_imm & (i_id_rt == r_rd))) & ~i_flush;
  assign w_capture = ~i_flush & ~w_stall & i_id_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_rd        <= '0;
      r_op_code   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_src[i] <= '0;
        r_val[i] <= '0;
      end
    end else if (w_capture) begin
      r_valid     <= 1'b1;
      r_reg_write <= i_id_reg_write;
      r_mem_read  <= i_id_mem_read;
      r_rd        <= i_id_rd;
      r_op_code   <= i_id_op_code;
      r_imm       <= i_id_imm;
      r_use_imm   <= i_id_use_imm;
      for (int i = 0; i < 2; i++) begin
        r_src[i] <= w_id_src[i];
        r_val[i] <= w_cap_val[i];
      end
    end else begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_rd        <= '0;
      r_op_code   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_src[i] <= '0;
        r_val[i] <= '0;
      end
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_count <= '0;
    end else if (w_stall | i_flush) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_stall_count = r_stall_count;
`endif

  assign o_stall        = w_stall;
  assign o_alu_op_code  = r_op_code;
  assign o_alu_a        = w_fwd[0];
  assign o_alu_b        = r_use_imm ? r_imm : w_fwd[1];
  assign o_ex_rt_val    = w_fwd[1];
  assign o_ex_valid     = r_valid;
  assign o_ex_reg_write = r_reg_write;
  assign o_ex_mem_read  = r_mem_read;
  assign o_ex_rd        = r_rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed cycles push expected stall/EX outputs, a monitor pops and compares.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [3:0]  id_op_code = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [31:0] id_rs_val = '0, id_rt_val = '0, id_imm = '0;
  logic        id_use_imm = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic        flush = 1'b0;
  logic        ex_mem_reg_write = 1'b0;
  logic [4:0]  ex_mem_rd = '0;
  logic [31:0] ex_mem_val = '0;
  logic        mem_wb_reg_write = 1'b0;
  logic [4:0]  mem_wb_rd = '0;
  logic [31:0] mem_wb_val = '0;
  logic        stall;
  logic [3:0]  alu_op_code;
  logic [31:0] alu_a, alu_b, ex_rt_val;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        valid;
    logic        rw;
    logic        mr;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rtv;
  } exp_t;

  exp_t exp_q[$];

  id_ex_stage #(.WIDTH(32), .REGBITS(5)) dut (
    .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_op_code(id_op_code),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
    .i_id_rs_val(id_rs_val), .i_id_rt_val(id_rt_val), .i_id_imm(id_imm),
    .i_id_use_imm(id_use_imm), .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
    .i_flush(flush),
    .i_ex_mem_reg_write(ex_mem_reg_write), .i_ex_mem_rd(ex_mem_rd), .i_ex_mem_val(ex_mem_val),
    .i_mem_wb_reg_write(mem_wb_reg_write), .i_mem_wb_rd(mem_wb_rd), .i_mem_wb_val(mem_wb_val),
    .o_stall(stall), .o_alu_op_code(alu_op_code), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_ex_valid(ex_valid), .o_ex_reg_write(ex_reg_write), .o_ex_mem_read(ex_mem_read),
    .o_ex_rd(ex_rd),
`ifdef ID_EX_STALL_CNT_EN
    .o_stall_count(stall_count),
`endif
    .o_ex_rt_val(ex_rt_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic [31:0] imm, input logic ui, input logic rw, input logic mr);
    id_valid = v; id_op_code = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
    id_use_imm = ui; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ev,
                         input logic ww, input logic [4:0] wr, input logic [31:0] wv);
    ex_mem_reg_write = ew; ex_mem_rd = er; ex_mem_val = ev;
    mem_wb_reg_write = ww; mem_wb_rd = wr; mem_wb_val = wv;
  endtask

  task automatic push(input logic s, input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                      input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] rtv);
    exp_t e;
    e.stall = s; e.valid = v; e.rw = rw; e.mr = mr; e.rd = rd; e.op = op; e.a = a; e.b = b; e.rtv = rtv;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_rw"}, {31'd0, ex_reg_write}, 32'd0);
    chk({tag, "_mr"}, {31'd0, ex_mem_read}, 32'd0);
    chk({tag, "_rd"}, {27'd0, ex_rd}, 32'd0);
    chk({tag, "_op"}, {28'd0, alu_op_code}, 32'd0);
    chk({tag, "_a"}, alu_a, 32'd0);
    chk({tag, "_b"}, alu_b, 32'd0);
`ifdef ID_EX_STALL_CNT_EN
    chk({tag, "_cnt"}, stall_count, 32'd0);
`endif
  endtask

  // Monitor: stall sampled after the drive point, EX outputs sampled after the following edge.
  initial begin
    logic s_sample;
    int   txn = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      s_sample = stall;
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("t%0d_stall", txn), {31'd0, s_sample}, {31'd0, e.stall});
        chk($sformatf("t%0d_valid", txn), {31'd0, ex_valid}, {31'd0, e.valid});
        chk($sformatf("t%0d_rw", txn), {31'd0, ex_reg_write}, {31'd0, e.rw});
        chk($sformatf("t%0d_mr", txn), {31'd0, ex_mem_read}, {31'd0, e.mr});
        chk($sformatf("t%0d_rd", txn), {27'd0, ex_rd}, {27'd0, e.rd});
        chk($sformatf("t%0d_op", txn), {28'd0, alu_op_code}, {28'd0, e.op});
        chk($sformatf("t%0d_a", txn), alu_a, e.a);
        chk($sformatf("t%0d_b", txn), alu_b, e.b);
        chk($sformatf("t%0d_rtv", txn), ex_rt_val, e.rtv);
        $display("txn %0d stall=%0b valid=%0b rd=%0d op=%h a=%h b=%h rtv=%h", txn, s_sample, ex_valid,
                 ex_rd, alu_op_code, alu_a, alu_b, ex_rt_val);
        txn++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cycles;
    #12;
    check_reset_state("init_reset");
    @(negedge clk); reset = 1'b0;

    // C1: ADD r3,r1,r2
    @(negedge clk); set_id(1, 4'b0000, 1, 2, 3, 32'd5, 32'd7, 32'd0, 0, 1, 0); set_fwd(0, 0, 0, 0, 0, 0);
    push(0, 1, 1, 0, 3, 4'b0000, 32'd5, 32'd7, 32'd7);
    // C2: OR r6,r3,r3 with both forwarding stages on r3: EX/MEM wins
    @(negedge clk); set_id(1, 4'b0101, 3, 3, 6, 32'h99, 32'h99, 32'd0, 0, 1, 0);
    set_fwd(1, 3, 32'h10, 1, 3, 32'h20);
    push(0, 1, 1, 0, 6, 4'b0101, 32'h10, 32'h10, 32'h10);
    // C3: EX/MEM not writing -> MEM/WB value
    @(negedge clk); set_id(1, 4'b0101, 3, 3, 6, 32'h99, 32'h99, 32'd0, 0, 1, 0);
    set_fwd(0, 3, 32'h10, 1, 3, 32'h20);
    push(0, 1, 1, 0, 6, 4'b0101, 32'h20, 32'h20, 32'h20);
    // C4: both rd=0 -> held register-file value
    @(negedge clk); set_id(1, 4'b0101, 3, 3, 6, 32'h99, 32'h99, 32'd0, 0, 1, 0);
    set_fwd(1, 0, 32'h10, 1, 0, 32'h20);
    push(0, 1, 1, 0, 6, 4'b0101, 32'h99, 32'h99, 32'h99);
    // C5: immediate B operand, rt still forwarded to store data
    @(negedge clk); set_id(1, 4'b0000, 1, 9, 8, 32'h100, 32'h55, 32'hFFFF_FFF0, 1, 1, 0);
    set_fwd(1, 9, 32'h77, 0, 0, 0);
    push(0, 1, 1, 0, 8, 4'b0000, 32'h100, 32'hFFFF_FFF0, 32'h77);
    // C6: LW r4,4(r1)
    @(negedge clk); set_id(1, 4'b0000, 1, 4, 4, 32'h200, 32'd0, 32'd4, 1, 1, 1); set_fwd(0, 0, 0, 0, 0, 0);
    push(0, 1, 1, 1, 4, 4'b0000, 32'h200, 32'd4, 32'd0);
    // C7: SUB r5,r4,r1 -> load-use stall, bubble
    @(negedge clk); set_id(1, 4'b0001, 4, 1, 5, 32'd0, 32'd3, 32'd0, 0, 1, 0); set_fwd(0, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 0, 4'b0000, 32'd0, 32'd0, 32'd0);
    // C8: SUB held in ID, load data now in MEM/WB
    @(negedge clk); set_id(1, 4'b0001, 4, 1, 5, 32'd0, 32'd3, 32'd0, 0, 1, 0);
    set_fwd(0, 0, 0, 1, 4, 32'hDEAD);
    push(0, 1, 1, 0, 5, 4'b0001, 32'hDEAD, 32'd3, 32'd3);
    // C9: LW r4 again
    @(negedge clk); set_id(1, 4'b0000, 1, 4, 4, 32'h200, 32'd0, 32'd4, 1, 1, 1); set_fwd(0, 0, 0, 0, 0, 0);
    push(0, 1, 1, 1, 4, 4'b0000, 32'h200, 32'd4, 32'd0);
    // C10: hazard plus flush -> no stall, bubble
    @(negedge clk); flush = 1'b1; set_id(1, 4'b0001, 4, 1, 5, 32'd0, 32'd3, 32'd0, 0, 1, 0);
    push(0, 0, 0, 0, 0, 4'b0000, 32'd0, 32'd0, 32'd0);
    // C11: capture-side bypass of a stale rs read
    @(negedge clk); flush = 1'b0; set_id(1, 4'b0000, 7, 0, 2, 32'd0, 32'd0, 32'd0, 0, 1, 0);
    set_fwd(0, 0, 0, 1, 7, 32'hABCD);
    push(0, 1, 1, 0, 2, 4'b0000, 32'hABCD, 32'd0, 32'd0);
    // C12: r0 is never forwarded
    @(negedge clk); set_id(1, 4'b0110, 0, 0, 1, 32'd0, 32'd0, 32'd0, 0, 1, 0);
    set_fwd(1, 0, 32'h5, 1, 0, 32'h6);
    push(0, 1, 1, 0, 1, 4'b0110, 32'd0, 32'd0, 32'd0);
    // C13: SRA with immediate
    @(negedge clk); set_id(1, 4'b1010, 1, 0, 2, 32'h8000_0000, 32'd0, 32'd4, 1, 1, 0); set_fwd(0, 0, 0, 0, 0, 0);
    push(0, 1, 1, 0, 2, 4'b1010, 32'h8000_0000, 32'd4, 32'd0);
    // C14: idValid=0 with garbage fields -> bubble
    @(negedge clk); set_id(0, 4'b1001, 4, 4, 9, 32'h1234, 32'h5678, 32'h9, 0, 1, 1);
    push(0, 0, 0, 0, 0, 4'b0000, 32'd0, 32'd0, 32'd0);
    // C15: flush of a valid instruction
    @(negedge clk); flush = 1'b1; set_id(1, 4'b0000, 1, 2, 3, 32'd5, 32'd7, 32'd0, 0, 1, 0);
    push(0, 0, 0, 0, 0, 4'b0000, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #3;
`ifdef ID_EX_STALL_CNT_EN
    chk("stall_count", stall_count, 32'd3);
`endif
    // C16: in-flight ADD, then asynchronous reset mid-cycle
    @(negedge clk); flush = 1'b0; set_id(1, 4'b0000, 1, 2, 3, 32'd5, 32'd7, 32'd0, 0, 1, 0);
    push(0, 1, 1, 0, 3, 4'b0000, 32'd5, 32'd7, 32'd7);
    @(posedge clk); #4;
    reset = 1'b1;
    #1;
    check_reset_state("mid_reset");
    // C17: first edge after release captures normally
    @(negedge clk); reset = 1'b0; set_id(1, 4'b0000, 1, 2, 3, 32'd5, 32'd7, 32'd0, 0, 1, 0);
    push(0, 1, 1, 0, 3, 4'b0000, 32'd5, 32'd7, 32'd7);
    @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the multi-stage processor, directly upstream of the 32-bit ALU; drives the ALU opCode, a and b ports.
- Captures decoded instruction fields from ID and applies EX/MEM and MEM/WB operand forwarding to the ALU inputs.
- Detects load-use hazards, requests an ID stall and inserts bubbles; a flush input kills the instruction being captured.

Parameters:
- WIDTH, 32, datapath width (ALU operand width).
- REGBITS, 5, register-specifier width (32 architectural registers, r0 hard-wired to zero).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- idValid  in  1  ID holds a real instruction
- idOpCode  in  4  ALU opcode (ADD 0000, SUB 0001, OR 0101, AND/XOR 0110, SLL 1000, SRL 1001, SRA 1010)
- idRs, idRt, idRd  in  REGBITS each  source/destination specifiers
- idRsVal, idRtVal  in  WIDTH each  register-file read data
- idImm  in  WIDTH  sign-extended immediate
- idUseImm  in  1  B operand = immediate
- idRegWrite, idMemRead  in  1 each  control bits
- flush  in  1  kill instruction entering EX
- exMemRegWrite  in  1;  exMemRd  in  REGBITS;  exMemVal  in  WIDTH  EX/MEM result
- memWbRegWrite  in  1;  memWbRd  in  REGBITS;  memWbVal  in  WIDTH  MEM/WB writeback
- stall  out  1  hold PC and IF/ID (combinational)
- aluOpCode  out  4;  aluA, aluB  out  WIDTH  ALU inputs
- exValid, exRegWrite, exMemRead  out  1 each;  exRd  out  REGBITS;  exRtVal  out  WIDTH  forwarded rt value, used as store data

Behaviour:
- Reset, asynchronous: all registers clear. exValid=0, exRegWrite=0, exMemRead=0, exRd=0, aluOpCode=0000, held data=0, so aluA=aluB=0 unless forwarding hits.
- Latency is one cycle. Fields captured at edge N appear on the outputs after edge N.
- Capture priority at each rising edge:
  - flush=1: bubble.
  - else stall=1: bubble.
  - else idValid=0: bubble.
  - else capture the ID fields.
- A bubble zeroes valid, regWrite, memRead, rd and opCode. Data registers are don't-care but are zeroed.
- Capture-side bypass: if memWbRegWrite, memWbRd!=0 and memWbRd==idRs, capture memWbVal instead of idRsVal. The same rule applies to idRt. This covers the register-file write/read in the same cycle.
- Hazard: stall = idValid & exValid & exMemRead & (exRd!=0) & ((idRs==exRd) | (~idUseImm & idRt==exRd)) & ~flush.
  - A stall lasts exactly one cycle per load. The following cycle holds a bubble, so stall deasserts and MEM/WB forwarding supplies the value.
- Execute-side forwarding, combinational from held rs/rt plus the forwarding inputs:
  - If exMemRegWrite, exMemRd!=0 and exMemRd==rsReg, fwdA=exMemVal.
  - Else if memWbRegWrite, memWbRd!=0 and memWbRd==rsReg, fwdA=memWbVal.
  - Else fwdA=held rs value. fwdB uses the same rule on rtReg.
  - EX/MEM has priority over MEM/WB. r0 is never forwarded.
- Outputs: aluA=fwdA; aluB = useImmReg ? immReg : fwdB; exRtVal=fwdB.
- While exValid=0, forwarding still evaluates (data unused) and exRegWrite/exMemRead stay 0.
- Reset mid-stream drops the in-flight instruction. The first edge after reset release captures normally.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined: adds output stallCount (32 bits). It resets to 0 and increments on every rising edge where stall=1 or flush=1, wrapping 0xFFFFFFFF to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset asserted mid-operation with exValid=1 -> outputs immediately exValid=0, exRegWrite=0, aluOpCode=0000, aluA=aluB=0 (no forwarding active); first post-release edge captures ADD r3,r1,r2 normally.
- ADD r3,r1,r2 with idRsVal=5, idRtVal=7, no forwarding -> next cycle aluOpCode=0000, aluA=5, aluB=7, exRd=3, exRegWrite=1.
- Back-to-back forward: exMemRd=3, exMemVal=0x10, memWbRd=3, memWbVal=0x20, held rs=3 -> aluA=0x10. With exMemRegWrite=0 -> aluA=0x20. With rd=0 on both -> aluA=held value.
- Load-use: EX holds LW r4 (exMemRead=1, exRd=4), ID=SUB r5,r4,r1 -> stall=1 for one cycle. Bubble enters EX (exValid=0), then SUB captured with aluOpCode=0001 and r4 forwarded from MEM/WB.
- flush=1 and a load-use hazard in the same cycle -> stall=0, bubble captured, exValid=0 next cycle.
- Capture-side bypass: idRs=7, idRsVal=0 (stale), memWbRegWrite=1, memWbRd=7, memWbVal=0xABCD -> aluA=0xABCD next cycle. With ID_EX_STALL_CNT_EN defined, stallCount counts 3 after one stall and two flush cycles.
